hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 101 ++++++++++
 tb/tb_hazard_scoreboard.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Register-hazard scoreboard: per-register pending-latency counters driving RAW/WAW stalls.
// Optional stall statistics counter enabled by defining HAZARD_SCOREBOARD_STATS_EN.
module hazard_scoreboard #(
   parameter int NREG    = 32,
   parameter int LAT_W   = 3,
   parameter int MAX_LAT = 7
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    issue_valid,
   input  logic [$clog2(NREG)-1:0] issue_rs,
   input  logic [$clog2(NREG)-1:0] issue_rt,
   input  logic                    use_rs,
   input  logic                    use_rt,
   input  logic                    wr_en,
   input  logic [$clog2(NREG)-1:0] wr_reg,
   input  logic [LAT_W-1:0]        wr_lat,
   input  logic                    flush,
   output logic                    stall,
   output logic                    issue_fire,
   output logic [NREG-1:0]         pend_mask,
   output logic [31:0]             stall_cycles
);

   localparam logic [LAT_W-1:0] MAX_LAT_V = LAT_W'(MAX_LAT);

   logic [LAT_W-1:0] cnt_q [NREG];
   logic [LAT_W-1:0] cnt_d [NREG];
   logic [NREG-1:0]  pend_mask_q, pend_mask_d;
   logic [LAT_W-1:0] lat_eff;
   logic             wr_live, raw_rs, raw_rt, waw;

   // Hazard detection looks only at the counters as they stand this cycle, so a
   // counter reaching zero releases the stall in that same cycle.
   always_comb begin
      lat_eff    = (wr_lat > MAX_LAT_V) ? MAX_LAT_V : wr_lat;
      wr_live    = wr_en && (wr_reg != '0);
      raw_rs     = use_rs && (issue_rs != '0) && (cnt_q[issue_rs] != '0);
      raw_rt     = use_rt && (issue_rt != '0) && (cnt_q[issue_rt] != '0);
      waw        = wr_live && (cnt_q[wr_reg] > lat_eff);
      stall      = issue_valid && !flush && (raw_rs || raw_rt || waw);
      issue_fire = issue_valid && !stall && !flush;
   end

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      cnt_d[0]    = '0;
      pend_mask_d = '0;
      for (int i = 1; i < NREG; i++) begin
         cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - LAT_W'(1) : cnt_q[i];
      end
      if (issue_fire && wr_live) begin
         cnt_d[wr_reg] = lat_eff;
      end
      for (int i = 1; i < NREG; i++) begin
         pend_mask_d[i] = (cnt_d[i] != '0);
      end
   end

   // NOTE: the counter array is reset explicitly: a stale nonzero count left over from before reset would raise spurious stalls.
   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            cnt_q[i] <= '0;
         end
         pend_mask_q <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         pend_mask_q <= pend_mask_d;
      end
   end

   assign pend_mask = pend_mask_q;

`ifdef HAZARD_SCOREBOARD_STATS_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (stall && (stall_cycles_q != '1)) begin
         stall_cycles_d = stall_cycles_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles_q <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
`else
   assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: a ready-time reference model queues the expected
// outputs of every cycle and a negedge monitor compares them against the DUT.
module tb_hazard_scoreboard;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       issue_valid = 1'b0;
   logic [4:0] issue_rs = '0, issue_rt = '0, wr_reg = '0;
   logic       use_rs = 1'b0, use_rt = 1'b0, wr_en = 1'b0, flush = 1'b0;
   logic [2:0] wr_lat = '0;
   logic       stall, issue_fire;
   logic [31:0] pend_mask, stall_cycles;

   hazard_scoreboard #(.NREG(32), .LAT_W(3), .MAX_LAT(7)) dut (
      .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid),
      .issue_rs(issue_rs), .issue_rt(issue_rt), .use_rs(use_rs), .use_rt(use_rt),
      .wr_en(wr_en), .wr_reg(wr_reg), .wr_lat(wr_lat), .flush(flush),
      .stall(stall), .issue_fire(issue_fire), .pend_mask(pend_mask),
      .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        stall;
      logic        fire;
      logic [31:0] pend;
      logic [31:0] sc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: each register remembers the absolute cycle at which its
   // result becomes forwardable; pending latency is the distance to that cycle.
   int          cyc = 0;
   int          ready [32];
   int unsigned stall_count = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int rem(input int r);
      if (r == 0) return 0;
      return (ready[r] > cyc) ? ready[r] - cyc : 0;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < 32; r++) ready[r] = 0;
      stall_count = 0;
   endtask

   // Drives one cycle of inputs and queues what the DUT must show during that cycle.
   task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic we,
                       input logic [4:0] wr, input logic [2:0] lat, input logic fl);
      exp_t e;
      int   lat_eff;
      logic hz;
      @(posedge clk);
      #1;
      issue_valid = v; issue_rs = rs; issue_rt = rt; use_rs = urs; use_rt = urt;
      wr_en = we; wr_reg = wr; wr_lat = lat; flush = fl;
      lat_eff = (int'(lat) > 7) ? 7 : int'(lat);
      hz = (urs && rem(int'(rs)) != 0) || (urt && rem(int'(rt)) != 0) ||
           (we && wr != 0 && rem(int'(wr)) > lat_eff);
      e.stall = v && !fl && hz;
      e.fire  = v && !fl && !hz;
      e.pend  = '0;
      for (int r = 1; r < 32; r++) e.pend[r] = (rem(r) != 0);
`ifdef HAZARD_SCOREBOARD_STATS_EN
      e.sc = stall_count;
      if (e.stall && stall_count != 32'hFFFF_FFFF) stall_count++;
`else
      e.sc = 32'd0;
`endif
      exp_q.push_back(e);
      if (e.fire && we && wr != 0) ready[wr] = cyc + lat_eff + 1;
   endtask

   task automatic idle();
      step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0);
   endtask

   // Holds one instruction in ID until it issues, counting the DUT's stall cycles.
   task automatic issue_until_fire(input string name, input logic [4:0] rs, input logic [4:0] rt,
                                   input logic urs, input logic urt, input logic we,
                                   input logic [4:0] wr, input logic [2:0] lat,
                                   input int exp_stalls);
      int n = 0;
      bit fired = 1'b0;
      for (int k = 0; k < 20 && !fired; k++) begin
         step(1'b1, rs, rt, urs, urt, we, wr, lat, 1'b0);
         @(negedge clk);
         #1;
         if (issue_fire) fired = 1'b1;
         else if (stall) n++;
      end
      check({name, " issued"}, 32'(fired), 32'd1);
      check({name, " stall cycles"}, n, exp_stalls);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("stall", 32'(stall), 32'(e.stall));
         check("issue_fire", 32'(issue_fire), 32'(e.fire));
         check("pend_mask", pend_mask, e.pend);
         check("stall_cycles", stall_cycles, e.sc);
      end
   end

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_reset();
      #1;
      check("reset pend_mask", pend_mask, 32'd0);
      check("reset stall_cycles", stall_cycles, 32'd0);
      #19 rst_n = 1'b1;

      // Load to $8 then a dependent add: exactly one stall cycle.
      step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 3'd1, 1'b0);
      issue_until_fire("load-use", 5'd8, 5'd10, 1'b1, 1'b1, 1'b1, 5'd9, 3'd0, 1);
      repeat (2) idle();

      // Latency-4 writer of $5 followed by a reader each cycle.
      step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 3'd4, 1'b0);
      issue_until_fire("lat4 reader", 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 3'd0, 4);
      repeat (2) idle();

      // WAW: $5 pending at 3, new writer with latency 1 waits until counter <= 1.
      step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 3'd4, 1'b0);
      idle();
      issue_until_fire("waw", 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 3'd1, 2);
      repeat (3) idle();

      // Writes to $0 are never pending and reads of $0 never stall.
      step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 3'd3, 1'b0);
      issue_until_fire("zero reg", 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 3'd0, 0);
      idle();

      // Flush suppresses stall and issue while $7 keeps counting down.
      step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 3'd2, 1'b0);
      step(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd11, 3'd0, 1'b1);
      step(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd11, 3'd0, 1'b1);
      repeat (2) idle();

      // Asynchronous reset with $3 pending at 5.
      step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3, 3'd5, 1'b0);
      idle();
      @(negedge clk);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      check("async reset pend_mask", pend_mask, 32'd0);
      check("async reset stall_cycles", stall_cycles, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0, 5'd0, 3'd0, 1'b0);
      idle();

      // Random traffic over a small register window to keep hazards frequent.
      for (int n = 0; n < 500; n++) begin
         step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), $urandom_range(0, 7) == 0);
      end
      idle();
      @(negedge clk);
      #1;
      check("scoreboard drained", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
